// File: rtl/dram_dec_pkg.sv
// Shared types and constants for the DRAM row/word-line decoder.
// The command scheduler imports the same default widths.
package dram_dec_pkg;

   localparam int DEF_ADDR_W   = 3;
   localparam int DEF_HOLD_CYC = 1;
   localparam int MAX_ADDR_W   = 8;
   localparam int MAX_OUT_W    = 2 ** MAX_ADDR_W;

   typedef enum logic {
      IDLE    = 1'b0,
      REFRESH = 1'b1
   } state_e;

   // Reference one-hot pattern at the widest legal size; callers zero-extend to compare.
   function automatic logic [MAX_OUT_W-1:0] onehot_f(input logic [MAX_ADDR_W-1:0] idx);
      onehot_f      = '0;
      onehot_f[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/dram_onehot_dec.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder feeding the row-select register.
module dram_onehot_dec
   import dram_dec_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic [ADDR_W-1:0]      addr_i,
   output logic [(2**ADDR_W)-1:0] onehot_o
);

   // One output line per address value.
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < 2 ** ADDR_W; i++) begin
         onehot_o[i] = (addr_i == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/dram_row_decoder.sv
// Registered one-hot row decoder serving on-demand requests and a refresh sweep.
// Optional sticky one-hot integrity flag enabled by DRAM_ROW_DEC_ONEHOT_CHK_EN.
module dram_row_decoder
   import dram_dec_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int HOLD_CYC = DEF_HOLD_CYC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic [ADDR_W-1:0]        req_addr,
   output logic                     req_ready,
   input  logic                     ref_start,
   output logic                     ref_busy,
   output logic                     ref_done,
   output logic [(2**ADDR_W)-1:0]   sel,
   output logic [ADDR_W-1:0]        sel_idx,
   output logic                     sel_valid
`ifdef DRAM_ROW_DEC_ONEHOT_CHK_EN
   ,output logic                    onehot_err
`endif
);

   localparam int OUT_W = 2 ** ADDR_W;
   localparam int HW    = $clog2(HOLD_CYC + 1);

   state_e            state_q;
   logic [ADDR_W-1:0] row_q;
   logic [HW-1:0]     hold_q;
   logic [OUT_W-1:0]  sel_q;
   logic [ADDR_W-1:0] sel_idx_q;
   logic              sel_valid_q;
   logic              busy_q;
   logic              done_q;

   logic [ADDR_W-1:0] dec_addr;
   logic [OUT_W-1:0]  sel_d;
   logic              hold_last;
   logic              row_last;

   // Terminal detection compares against the maximum so counters never wrap mid-row.
   assign hold_last = (hold_q == HW'(HOLD_CYC - 1));
   assign row_last  = (row_q == ADDR_W'(OUT_W - 1));

   // Refresh has priority: a pending request waits while a sweep starts or runs.
   assign req_ready = (state_q == IDLE) && !ref_start;

   // Single decoder: its address comes from the requester or the next sweep row.
   always_comb begin
      dec_addr = req_addr;
      if (state_q == REFRESH) begin
         dec_addr = hold_last ? row_q + ADDR_W'(1) : row_q;
      end else if (ref_start) begin
         dec_addr = '0;
      end
   end

   dram_onehot_dec #(
      .ADDR_W   (ADDR_W)
   ) u_dec (
      .addr_i   (dec_addr),
      .onehot_o (sel_d)
   );

   // Control FSM with registered select outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         row_q       <= '0;
         hold_q      <= '0;
         sel_q       <= '0;
         sel_idx_q   <= '0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (ref_start) begin
               state_q     <= REFRESH;
               row_q       <= '0;
               hold_q      <= '0;
               sel_q       <= sel_d;
               sel_idx_q   <= dec_addr;
               sel_valid_q <= 1'b1;
               busy_q      <= 1'b1;
            end else if (req_valid) begin
               sel_q       <= sel_d;
               sel_idx_q   <= dec_addr;
               sel_valid_q <= 1'b1;
            end else begin
               sel_q       <= '0;
               sel_idx_q   <= '0;
               sel_valid_q <= 1'b0;
            end
         end else begin
            if (hold_last) begin
               hold_q <= '0;
               if (row_last) begin
                  state_q     <= IDLE;
                  row_q       <= '0;
                  sel_q       <= '0;
                  sel_idx_q   <= '0;
                  sel_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  row_q     <= row_q + ADDR_W'(1);
                  sel_q     <= sel_d;
                  sel_idx_q <= dec_addr;
               end
            end else begin
               hold_q <= hold_q + HW'(1);
            end
         end
      end
   end

   assign sel       = sel_q;
   assign sel_idx   = sel_idx_q;
   assign sel_valid = sel_valid_q;
   assign ref_busy  = busy_q;
   assign ref_done  = done_q;

`ifdef DRAM_ROW_DEC_ONEHOT_CHK_EN
   logic err_q;

   // Sticky flag: a valid select that is not exactly the one-hot of its index.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (sel_valid_q &&
                   (MAX_OUT_W'(sel_q) != onehot_f(MAX_ADDR_W'(sel_idx_q)))) begin
         err_q <= 1'b1;
      end
   end

   assign onehot_err = err_q;
`endif

endmodule

// File: tb/tb_dram_row_decoder.sv
// Self-checking bench for dram_row_decoder (ADDR_W=3, HOLD_CYC=2).
module tb_dram_row_decoder;

   localparam int AW    = 3;
   localparam int HOLD  = 2;
   localparam int OUT_W = 8;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic [AW-1:0] req_addr;
   logic          req_ready;
   logic          ref_start;
   logic          ref_busy;
   logic          ref_done;
   logic [OUT_W-1:0] sel;
   logic [AW-1:0] sel_idx;
   logic          sel_valid;
`ifdef DRAM_ROW_DEC_ONEHOT_CHK_EN
   logic          onehot_err;
`endif

   int checks = 0;
   int errors = 0;

   dram_row_decoder #(
      .ADDR_W    (AW),
      .HOLD_CYC  (HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .ref_start (ref_start),
      .ref_busy  (ref_busy),
      .ref_done  (ref_done),
      .sel       (sel),
      .sel_idx   (sel_idx),
      .sel_valid (sel_valid)
`ifdef DRAM_ROW_DEC_ONEHOT_CHK_EN
      ,.onehot_err (onehot_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a sweep is a count of elapsed cycles; the row is count/HOLD.
   bit m_known = 0;
   bit cmp_en  = 1;
   bit m_sweep = 0;
   int m_cyc   = 0;
   int exp_sel, exp_idx, exp_valid, exp_busy, exp_done;

   always @(posedge clk) begin
      if (rst) begin
         m_sweep = 0; m_cyc = 0;
         exp_sel = 0; exp_idx = 0; exp_valid = 0; exp_busy = 0; exp_done = 0;
         m_known = 1;
      end else if (m_sweep) begin
         m_cyc++;
         exp_done = 0;
         if (m_cyc == OUT_W * HOLD) begin
            m_sweep = 0;
            exp_sel = 0; exp_idx = 0; exp_valid = 0; exp_busy = 0; exp_done = 1;
         end else begin
            exp_idx = m_cyc / HOLD; exp_sel = 1 << exp_idx; exp_valid = 1; exp_busy = 1;
         end
      end else begin
         exp_done = 0;
         if (ref_start) begin
            m_sweep = 1; m_cyc = 0;
            exp_idx = 0; exp_sel = 1; exp_valid = 1; exp_busy = 1;
         end else if (req_valid) begin
            exp_idx = int'(req_addr); exp_sel = 1 << exp_idx; exp_valid = 1; exp_busy = 0;
         end else begin
            exp_idx = 0; exp_sel = 0; exp_valid = 0; exp_busy = 0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_known && cmp_en) begin
         chk("model_sel",       32'(sel),       32'(exp_sel));
         chk("model_sel_idx",   32'(sel_idx),   32'(exp_idx));
         chk("model_sel_valid", 32'(sel_valid), 32'(exp_valid));
         chk("model_ref_busy",  32'(ref_busy),  32'(exp_busy));
         chk("model_ref_done",  32'(ref_done),  32'(exp_done));
         chk("model_req_ready", 32'(req_ready), 32'(!m_sweep && !ref_start));
      end
   end

   logic [7:0] sweep_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      bit found;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; ref_start = 1'b0;
      tick(); tick();
      @(negedge clk);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_sel_idx", 32'(sel_idx), 32'h0);
      chk("rst_sel_valid", 32'(sel_valid), 32'h0);
      chk("rst_busy", 32'(ref_busy), 32'h0);
      chk("rst_done", 32'(ref_done), 32'h0);

      // Single request, address 5.
      rst = 1'b0; req_valid = 1'b1; req_addr = 3'd5;
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("req5_sel", 32'(sel), 32'h20);
      chk("req5_idx", 32'(sel_idx), 32'd5);
      chk("req5_valid", 32'(sel_valid), 32'h1);
      tick();
      @(negedge clk);
      chk("req5_clear_sel", 32'(sel), 32'h0);
      chk("req5_clear_valid", 32'(sel_valid), 32'h0);

      // Back-to-back requests 0, 7, 3.
      req_valid = 1'b1; req_addr = 3'd0;
      tick(); req_addr = 3'd7;
      @(negedge clk); chk("b2b_sel0", 32'(sel), 32'h01);
      tick(); req_addr = 3'd3;
      @(negedge clk); chk("b2b_sel7", 32'(sel), 32'h80);
      tick(); req_valid = 1'b0;
      @(negedge clk); chk("b2b_sel3", 32'(sel), 32'h08);
      tick();
      @(negedge clk); chk("b2b_idle", 32'(sel), 32'h0);

      // Full sweep; a mid-sweep ref_start must be ignored.
      ref_start = 1'b1;
      tick(); ref_start = 1'b0;
      for (int k = 0; k < OUT_W * HOLD; k++) begin
         @(negedge clk);
         chk("sweep_sel", 32'(sel), 32'(sweep_tab[k / HOLD]));
         chk("sweep_valid", 32'(sel_valid), 32'h1);
         ref_start = (k == 5);
         tick();
         ref_start = 1'b0;
      end
      @(negedge clk);
      chk("sweep_done", 32'(ref_done), 32'h1);
      chk("sweep_done_sel", 32'(sel), 32'h0);
      chk("sweep_done_busy", 32'(ref_busy), 32'h0);
      tick();
      @(negedge clk);
      chk("sweep_done_pulse", 32'(ref_done), 32'h0);

      // Refresh beats a simultaneous request; request accepted in the done cycle.
      ref_start = 1'b1; req_valid = 1'b1; req_addr = 3'd2;
      @(negedge clk);
      chk("prio_ready_low", 32'(req_ready), 32'h0);
      tick(); ref_start = 1'b0;
      @(negedge clk);
      chk("prio_busy", 32'(ref_busy), 32'h1);
      chk("prio_sel_row0", 32'(sel), 32'h01);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ref_done) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("prio_done_seen", 32'(found), 32'h1);
      chk("prio_ready_in_done", 32'(req_ready), 32'h1);
      tick(); req_valid = 1'b0;
      @(negedge clk);
      chk("prio_sel_req2", 32'(sel), 32'h04);
      chk("prio_idx_req2", 32'(sel_idx), 32'd2);
      tick();

      // Reset mid-sweep at row 4, then restart from row 0.
      ref_start = 1'b1;
      tick(); ref_start = 1'b0;
      found = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (sel == 8'h10) begin
            found = 1;
            break;
         end
         tick();
      end
      chk("mid_row4_seen", 32'(found), 32'h1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("abort_sel", 32'(sel), 32'h0);
      chk("abort_valid", 32'(sel_valid), 32'h0);
      chk("abort_busy", 32'(ref_busy), 32'h0);
      chk("abort_done", 32'(ref_done), 32'h0);
      ref_start = 1'b1;
      tick(); ref_start = 1'b0;
      @(negedge clk); chk("restart_row0a", 32'(sel), 32'h01);
      tick();
      @(negedge clk); chk("restart_row0b", 32'(sel), 32'h01);
      tick();
      @(negedge clk); chk("restart_row1", 32'(sel), 32'h02);
      found = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         @(negedge clk);
         if (ref_done) begin
            found = 1;
            break;
         end
      end
      chk("restart_done_seen", 32'(found), 32'h1);
      tick();

`ifdef DRAM_ROW_DEC_ONEHOT_CHK_EN
      @(negedge clk);
      chk("chk_err_clear", 32'(onehot_err), 32'h0);
      cmp_en = 0;
      force dut.sel_q = 8'h03;
      force dut.sel_valid_q = 1'b1;
      tick(); tick();
      release dut.sel_q;
      release dut.sel_valid_q;
      tick(); tick();
      @(negedge clk);
      chk("chk_err_sticky", 32'(onehot_err), 32'h1);
      rst = 1'b1;
      tick(); rst = 1'b0;
      @(negedge clk);
      chk("chk_err_rst", 32'(onehot_err), 32'h0);
      cmp_en = 1;
      tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
